// File: rtl/gpio_input_stage.sv
// GPIO input path: pad synchroniser, per-pin debounce, edge detect.
// Feeds sync_in, intrpt and intrpt_valid of the register block.
module gpio_input_stage #(
    parameter int NumGpios      = 32,
    parameter int SyncStages    = 2,
    parameter int DebounceWidth = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NumGpios-1:0]      gpio_in_i,
    input  logic [DebounceWidth-1:0] debounce_cycles_i,
    input  logic [NumGpios-1:0]      intrpt_en_i,
    input  logic [NumGpios-1:0]      intrpt_edge_i,
    input  logic [NumGpios-1:0]      intrpt_status_i,
    output logic [NumGpios-1:0]      sync_in_o,
    output logic [NumGpios-1:0]      intrpt_o,
    output logic [NumGpios-1:0]      intrpt_valid_o,
    output logic                     irq_o
);

    logic [SyncStages-1:0][NumGpios-1:0]    sync_q;
    logic [SyncStages-1:0][NumGpios-1:0]    sync_d;
    logic [NumGpios-1:0]                    db_q;
    logic [NumGpios-1:0]                    db_d;
    logic [NumGpios-1:0]                    db_prev_q;
    logic [NumGpios-1:0]                    db_prev_d;
    logic [NumGpios-1:0][DebounceWidth-1:0] cnt_q;
    logic [NumGpios-1:0][DebounceWidth-1:0] cnt_d;
    logic                                   irq_q;
    logic                                   irq_d;

    logic [NumGpios-1:0]      s;
    logic [DebounceWidth-1:0] thr;
    logic [NumGpios-1:0]      edge_det;

    assign s = sync_q[SyncStages-1];

    // Shift the raw pad levels through the synchroniser chain.
    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = gpio_in_i;
        for (int i = 1; i < SyncStages; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Accept a new level once it has been stable for max(D,1) cycles.
    // The >= test lets a lowered D take effect immediately.
    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        thr   = (debounce_cycles_i == '0) ? '0
                                          : debounce_cycles_i - 1'b1;
        for (int p = 0; p < NumGpios; p++) begin
            if (s[p] == db_q[p]) begin
                cnt_d[p] = '0;
            end else if (cnt_q[p] >= thr) begin
                db_d[p]  = s[p];
                cnt_d[p] = '0;
            end else if (cnt_q[p] != '1) begin
                cnt_d[p] = cnt_q[p] + 1'b1;
            end
        end
    end

    // Track the previous debounced level and the registered irq.
    always_comb begin
        db_prev_d = db_q;
        irq_d     = |(intrpt_status_i & intrpt_en_i);
    end

    // All state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q    <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            cnt_q     <= '0;
            irq_q     <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            db_q      <= db_d;
            db_prev_q <= db_prev_d;
            cnt_q     <= cnt_d;
            irq_q     <= irq_d;
        end
    end

    // Strobe on the first cycle of a new level matching the edge select;
    // enable and edge select are taken live from the register block.
    always_comb begin
        edge_det       = db_q ^ db_prev_q;
        intrpt_valid_o = edge_det & intrpt_en_i & ~(db_q ^ intrpt_edge_i);
    end

    assign sync_in_o = db_q;
    assign intrpt_o  = '1;
    assign irq_o     = irq_q;

endmodule

// File: tb/tb_gpio_input_stage.sv
// Directed bench for gpio_input_stage: vector table for the D=0
// pipeline plus hand sequences for reset, debounce and mid-run reset.
module tb_gpio_input_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] gpio;
    logic [7:0]  dcyc;
    logic [31:0] en;
    logic [31:0] edg;
    logic [31:0] st;
    logic [31:0] sync_in;
    logic [31:0] intrpt;
    logic [31:0] valid;
    logic        irq;

    int checks = 0;
    int fails  = 0;

    gpio_input_stage dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .gpio_in_i         (gpio),
        .debounce_cycles_i (dcyc),
        .intrpt_en_i       (en),
        .intrpt_edge_i     (edg),
        .intrpt_status_i   (st),
        .sync_in_o         (sync_in),
        .intrpt_o          (intrpt),
        .intrpt_valid_o    (valid),
        .irq_o             (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] gpio;
        logic [31:0] en;
        logic [31:0] edg;
        logic [31:0] st;
        logic [31:0] e_sync;
        logic [31:0] e_valid;
        logic        e_irq;
    } vec_t;

    vec_t tbl[23];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_row(input int i, input logic [31:0] g,
                           input logic [31:0] e, input logic [31:0] d,
                           input logic [31:0] s, input logic [31:0] xs,
                           input logic [31:0] xv, input logic xi);
        tbl[i].gpio    = g;
        tbl[i].en      = e;
        tbl[i].edg     = d;
        tbl[i].st      = s;
        tbl[i].e_sync  = xs;
        tbl[i].e_valid = xv;
        tbl[i].e_irq   = xi;
    endtask

    initial begin
        // gpio, en, edge, status -> sync, valid, irq (after one edge)
        set_row(0,  32'h0,   32'h0,  32'h0,  32'h0,  32'h0,  32'h0,  1'b0);
        set_row(1,  32'h9,   32'h9,  32'h8,  32'h0,  32'h0,  32'h0,  1'b0);
        set_row(2,  32'h9,   32'h9,  32'h8,  32'h0,  32'h0,  32'h0,  1'b0);
        set_row(3,  32'h9,   32'h9,  32'h8,  32'h0,  32'h9,  32'h8,  1'b0);
        set_row(4,  32'h1,   32'h9,  32'h8,  32'h0,  32'h9,  32'h0,  1'b0);
        set_row(5,  32'h0,   32'h9,  32'h8,  32'h0,  32'h9,  32'h0,  1'b0);
        set_row(6,  32'h0,   32'h9,  32'h8,  32'h0,  32'h1,  32'h0,  1'b0);
        set_row(7,  32'h0,   32'h9,  32'h8,  32'h0,  32'h0,  32'h1,  1'b0);
        set_row(8,  32'hF0,  32'h0,  32'hF0, 32'h10, 32'h0,  32'h0,  1'b0);
        set_row(9,  32'hF0,  32'h30, 32'hF0, 32'h10, 32'h0,  32'h0,  1'b1);
        set_row(10, 32'hF0,  32'hA0, 32'hF0, 32'h10, 32'hF0, 32'hA0, 1'b0);
        set_row(11, 32'hF0,  32'hA0, 32'hF0, 32'h10, 32'hF0, 32'h0,  1'b0);
        set_row(12, '1,      '1,     32'h0,  32'h0,  32'hF0, 32'h0,  1'b0);
        set_row(13, '1,      '1,     32'h0,  32'h0,  32'hF0, 32'h0,  1'b0);
        set_row(14, 32'h0,   '1,     '1,     32'h0,  '1,     32'hFFFF_FF0F, 1'b0);
        set_row(15, 32'h0,   '1,     32'h0,  32'h0,  '1,     32'h0,  1'b0);
        set_row(16, 32'h0,   '1,     32'h0,  32'h0,  32'h0,  '1,     1'b0);
        set_row(17, 32'h0,   '1,     32'h0,  32'h8000_0000, 32'h0, 32'h0, 1'b1);
        set_row(18, 32'h1,   32'h0,  32'h0,  32'h8000_0000, 32'h0, 32'h0, 1'b0);
        set_row(19, 32'h1,   32'h0,  32'h0,  32'h0,  32'h0,  32'h0,  1'b0);
        set_row(20, 32'h0,   32'h0,  32'h0,  32'h0,  32'h1,  32'h0,  1'b0);
        set_row(21, 32'h0,   32'h0,  32'h0,  32'h0,  32'h1,  32'h0,  1'b0);
        set_row(22, 32'h0,   32'h0,  32'h0,  32'h0,  32'h0,  32'h0,  1'b0);

        // Reset with all pads high.
        rst  = 1'b1;
        gpio = '1;
        dcyc = 8'd0;
        en   = '0;
        edg  = '0;
        st   = '0;
        step();
        step();
        chk("rst_sync",   sync_in, 32'h0);
        chk("rst_valid",  valid,   32'h0);
        chk("rst_irq",    {31'b0, irq}, 32'h0);
        chk("rst_intrpt", intrpt,  '1);
        rst = 1'b0;
        step();
        chk("rel1_sync",  sync_in, 32'h0);
        chk("rel1_valid", valid,   32'h0);
        chk("rel1_irq",   {31'b0, irq}, 32'h0);
        step();
        chk("rel2_sync",  sync_in, 32'h0);
        step();
        chk("rel3_sync",  sync_in, '1);
        chk("rel3_valid", valid,   32'h0);

        // Settle to all-low before the table.
        gpio = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("settle_valid", valid, 32'h0);
        end
        chk("settle_sync", sync_in, 32'h0);

        for (int i = 0; i < 23; i++) begin
            gpio = tbl[i].gpio;
            en   = tbl[i].en;
            edg  = tbl[i].edg;
            st   = tbl[i].st;
            step();
            chk($sformatf("v%0d_sync", i),  sync_in, tbl[i].e_sync);
            chk($sformatf("v%0d_valid", i), valid,   tbl[i].e_valid);
            chk($sformatf("v%0d_irq", i),   {31'b0, irq},
                {31'b0, tbl[i].e_irq});
        end

        // Debounce D=5: a 4-cycle pulse on pin7 is filtered out.
        dcyc = 8'd5;
        en   = 32'h80;
        edg  = 32'h80;
        st   = '0;
        gpio = 32'h80;
        for (int i = 0; i < 4; i++) step();
        gpio = 32'h0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("glitch_sync",  sync_in, 32'h0);
            chk("glitch_valid", valid,   32'h0);
        end

        // A held level is accepted exactly 2+5 cycles after the rise.
        gpio = 32'h80;
        for (int i = 0; i < 6; i++) step();
        chk("db6_sync",  sync_in, 32'h0);
        step();
        chk("db7_sync",  sync_in, 32'h80);
        chk("db7_valid", valid,   32'h80);
        step();
        chk("db8_valid", valid,   32'h0);
        chk("db8_sync",  sync_in, 32'h80);

        // Mid-run reset with pin5 counter at 3 of D=8.
        dcyc = 8'd8;
        en   = '0;
        gpio = 32'hA0;
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1;
        step();
        chk("mrst_sync",  sync_in, 32'h0);
        chk("mrst_valid", valid,   32'h0);
        chk("mrst_irq",   {31'b0, irq}, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 9; i++) step();
        chk("mrst9_sync", sync_in, 32'h0);
        step();
        chk("mrst10_sync", sync_in, 32'hA0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
